// File: rtl/clk_div_pwm.sv
// ============================================================================
// clk_div_pwm : run-time programmable clock divider / PWM with glitch-free
// reloads at period boundaries. Optional one-shot mode: CLKDIV_ONESHOT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module clk_div_pwm #(
  parameter int CNT_W      = 16,
  parameter int RST_PERIOD = 22153,
  parameter int RST_HIGH   = 4430
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] high,
  output logic             clk_out,
  output logic             period_end,
  output logic             pending
`ifdef CLKDIV_ONESHOT_EN
  ,
  input  logic             oneshot,
  output logic             done
`endif
);

  localparam logic [CNT_W-1:0] RST_PER_V = CNT_W'(RST_PERIOD);
  localparam logic [CNT_W-1:0] RST_HI_V  = CNT_W'(RST_HIGH);
  localparam logic [CNT_W-1:0] MIN_PER   = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] per_a, per_n;
  logic [CNT_W-1:0] hi_a, hi_n;
  logic [CNT_W-1:0] pend_per, pend_per_n;
  logic [CNT_W-1:0] pend_hi, pend_hi_n;
  logic             pending_n;
  logic             clk_out_n;
  logic             period_end_n;
  logic             apply_now;
  logic             wrap;
  logic [CNT_W-1:0] per_clamp;
  logic             os_req;
  logic             done_n;

`ifdef CLKDIV_ONESHOT_EN
  assign os_req = oneshot;
`else
  assign os_req = 1'b0;
`endif

  assign per_clamp = (period < MIN_PER) ? MIN_PER : period;
  assign wrap      = (state == ST_RUN) && (cnt == per_a - ONE);

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    per_n        = per_a;
    hi_n         = hi_a;
    pend_per_n   = pend_per;
    pend_hi_n    = pend_hi;
    pending_n    = pending;
    apply_now    = 1'b0;
    clk_out_n    = 1'b0;
    period_end_n = 1'b0;
    done_n       = 1'b0;

    if (!en) begin
      state_n   = ST_IDLE;
      cnt_n     = '0;
      apply_now = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          // first enabled cycle starts a fresh period at cnt = 0
          state_n   = ST_RUN;
          cnt_n     = '0;
          apply_now = 1'b1;
        end
        ST_RUN: begin
          if (wrap) begin
            cnt_n     = '0;
            apply_now = 1'b1;
            if (os_req) state_n = ST_HALT;
          end else begin
            cnt_n = cnt + ONE;
            if (load) begin
              pend_per_n = per_clamp;
              pend_hi_n  = high;
              pending_n  = 1'b1;
            end
          end
        end
        ST_HALT: begin
          cnt_n     = '0;
          apply_now = 1'b1;
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      endcase
    end

    // a load seen on a boundary cycle wins over an older pending value
    if (apply_now) begin
      if (load) begin
        per_n = per_clamp;
        hi_n  = high;
      end else if (pending) begin
        per_n = pend_per;
        hi_n  = pend_hi;
      end
      pending_n = 1'b0;
    end

    if (state_n == ST_RUN) begin
      clk_out_n    = (cnt_n < hi_n);
      period_end_n = (cnt_n == per_n - ONE);
    end
    done_n = en && os_req && (state_n == ST_HALT);
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      per_a      <= RST_PER_V;
      hi_a       <= RST_HI_V;
      pend_per   <= '0;
      pend_hi    <= '0;
      pending    <= 1'b0;
      clk_out    <= 1'b0;
      period_end <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      per_a      <= per_n;
      hi_a       <= hi_n;
      pend_per   <= pend_per_n;
      pend_hi    <= pend_hi_n;
      pending    <= pending_n;
      clk_out    <= clk_out_n;
      period_end <= period_end_n;
    end
  end

`ifdef CLKDIV_ONESHOT_EN
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) done <= 1'b0;
    else      done <= done_n;
  end
`else
  logic unused_done;
  assign unused_done = done_n;
`endif

endmodule

`default_nettype wire

// File: tb/tb_clk_div_pwm.sv
// ============================================================================
// tb_clk_div_pwm : scoreboard bench; per-cycle expected outputs from a
// period-level reference model are queued and checked by a monitor.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_clk_div_pwm;

  localparam int RST_P = 22153;
  localparam int RST_H = 4430;

  logic        clk_in = 1'b0;
  logic        rst    = 1'b0;
  logic        en     = 1'b0;
  logic        load   = 1'b0;
  logic [15:0] period = '0;
  logic [15:0] high   = '0;
  logic        clk_out, period_end, pending;
  logic        oneshot_s = 1'b0;
  logic        done_s;

  int checks   = 0;
  int failures = 0;

  clk_div_pwm dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .period     (period),
    .high       (high),
    .clk_out    (clk_out),
    .period_end (period_end),
    .pending    (pending)
`ifdef CLKDIV_ONESHOT_EN
    ,
    .oneshot    (oneshot_s),
    .done       (done_s)
`endif
  );

`ifndef CLKDIV_ONESHOT_EN
  assign done_s = 1'b0;
`endif

  always #5 clk_in = ~clk_in;

  // Reference model: where we are inside the current period, and which
  // period/high settings govern it.
  bit m_active, m_halt, m_pend;
  int m_pos, m_per, m_hi, m_pper, m_phi;
  logic [3:0] exp_q[$];

  function automatic int clamp(input int p);
    return (p < 2) ? 2 : p;
  endfunction

  task automatic adopt(input bit l, input int p, input int h);
    if (l) begin m_per = clamp(p); m_hi = h; end
    else if (m_pend) begin m_per = m_pper; m_hi = m_phi; end
    m_pend = 0;
  endtask

  task automatic model_step(input bit r, input bit e, input bit l,
                            input int p, input int h, input bit os,
                            output logic [3:0] ex);
    bit starts;
    if (!r) begin
      m_active = 0; m_halt = 0; m_pos = 0; m_per = RST_P; m_hi = RST_H; m_pend = 0;
      ex = 4'b0000;
      return;
    end
    if (!e) begin
      m_active = 0; m_halt = 0; m_pos = 0; adopt(l, p, h);
      ex = 4'b0000;
      return;
    end
    if (m_halt) begin
      m_pos = 0; adopt(l, p, h);
      ex = {3'b000, os};
      return;
    end
    starts = !m_active || (m_pos == m_per - 1);
`ifdef CLKDIV_ONESHOT_EN
    if (starts && m_active && os) begin
      m_halt = 1; m_active = 0; m_pos = 0; adopt(l, p, h);
      ex = 4'b0001;
      return;
    end
`endif
    if (starts) begin
      m_active = 1; m_pos = 0; adopt(l, p, h);
    end else begin
      m_pos++;
      if (l) begin m_pper = clamp(p); m_phi = h; m_pend = 1; end
    end
    ex = {m_pos < m_hi, m_pos == m_per - 1, m_pend, 1'b0};
  endtask

  task automatic step(input bit r, input bit e, input bit l,
                      input int p, input int h, input bit os);
    logic [3:0] ex;
    @(negedge clk_in);
    rst = r; en = e; load = l; period = p[15:0]; high = h[15:0]; oneshot_s = os;
    model_step(r, e, l, p, h, os, ex);
    exp_q.push_back(ex);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0);
  endtask

  task automatic run_to_pos(input int pos, input int budget);
    int k = 0;
    while (!(m_active && m_pos == pos) && k < budget) begin
      step(1, 1, 0, 0, 0, 0);
      k++;
    end
    checks++;
    if (k >= budget) begin
      failures++;
      $display("FAIL run_to_pos: position %0d not reached within %0d cycles (at %0d)", pos, budget, m_pos);
    end
  endtask

  // monitor: compares the DUT against the queued expectation after every edge
  always @(posedge clk_in) begin
    logic [3:0] ex, act;
    #1;
    if (exp_q.size() > 0) begin
      ex  = exp_q.pop_front();
      act = {clk_out, period_end, pending, done_s};
      checks++;
      if (act !== ex) begin
        failures++;
        $display("FAIL outs t=%0t {clk_out,period_end,pending,done} got=%b want=%b", $time, act, ex);
      end
    end
  end

  initial begin
    // reset state
    repeat (3) step(0, 0, 0, 0, 0, 0);

    // reset defaults: one full period plus the start of the next
    run(RST_P + 10);

    // mid-period load: current period finishes unchanged
    run_to_pos(100, RST_P + 5);
    step(1, 1, 1, 4079, 815, 0);
    run(RST_P + 2 * 4079);

    // load on the wrap cycle takes effect immediately
    run_to_pos(4078, 4100);
    step(1, 1, 1, 10, 5, 0);
    run(30);

    // degenerate values, applied at once while disabled
    step(1, 0, 1, 10, 0, 0);  run(25);
    step(1, 0, 1, 10, 12, 0); run(25);
    step(1, 0, 1, 0, 1, 0);   run(10);
    step(1, 0, 1, 1, 1, 0);   run(10);
    step(1, 0, 1, 10, 10, 0); run(25);

    // disable mid-run, load while disabled, reset mid-period with pending
    step(1, 0, 1, 100, 30, 0);
    run_to_pos(50, 200);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 60, 20, 0);
    step(1, 0, 0, 0, 0, 0);
    run(130);
    run_to_pos(10, 100);
    step(1, 1, 1, 7, 3, 0);
    run(5);
    @(negedge clk_in);
    rst = 0;
    #1;
    checks++;
    if (pending !== 1'b0 || clk_out !== 1'b0 || period_end !== 1'b0) begin
      failures++;
      $display("FAIL async_rst: pending=%b clk_out=%b period_end=%b want 0 0 0", pending, clk_out, period_end);
    end
    begin
      logic [3:0] ex;
      model_step(0, 1, 0, 0, 0, 0, ex);
      exp_q.push_back(ex);
    end
    step(0, 1, 0, 0, 0, 0);
    step(1, 0, 1, 12, 4, 0);
    run(40);

    // randomized traffic on small periods
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 599) != 0), ($urandom_range(0, 15) != 0),
           ($urandom_range(0, 7) == 0), $urandom_range(0, 20),
           $urandom_range(0, 24), 1'b0);
    end

`ifdef CLKDIV_ONESHOT_EN
    // one-shot: exactly one 3-high / 5-low pulse, then hold until en toggles
    step(1, 0, 1, 8, 3, 1);
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0, 1);
`endif

    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk_in);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
